exhaustive_vector_checker: RTL and testbench

- Synthesisable, self-checking exhaustive stimulus engine for small combinational blocks.
- Walks every input combination of an N_IN-bit combinational DUT and holds each vector for HOLD_CYCLES clocks.
- Samples the DUT's single-bit output at the end of each hold window and compares it with a parameterised truth table.
- Reports pass/fail, the mismatch count and the first failing vector; used on-board and in simulation wherever hand-written exhaustive stimulus was used before.

---
 rtl/exhaustive_vector_checker.sv | 177 +++++++++++++++++
 tb/tb_exhaustive_vector_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_vector_checker.sv
// -----------------------------------------------------------------------------
// exhaustive_vector_checker
//
// Drives every input combination of a small combinational block, holds each
// vector for HOLD_CYCLES clocks, samples the block's single-bit output at the
// end of each hold window and compares it against a truth table.
//
// Parameters
//   N_IN         DUT input width (1..8); 2^N_IN vectors per run
//   HOLD_CYCLES  clocks each vector is driven before it is sampled (>=1)
//   EXP_TABLE    expected output, bit k = response to applied vector value k
//   GRAY_MODE    0 = ascending binary order, 1 = Gray-code order
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            begin a run (honoured in IDLE or DONE only)
//   abort            cancel a run in progress
//   vec_out          vector driven to the DUT inputs (MSB = first DUT input)
//   dut_out          DUT output under test
//   busy             run in progress
//   done             run complete, held until the next start
//   pass             valid with done, 1 = zero mismatches
//   err_count        number of mismatching vectors
//   first_err_vec    applied value of the first mismatching vector
//   first_err_valid  first_err_vec holds a captured value
// -----------------------------------------------------------------------------
module exhaustive_vector_checker #(
    parameter int                     N_IN        = 4,
    parameter int                     HOLD_CYCLES = 10,
    parameter logic [(1<<N_IN)-1:0]   EXP_TABLE   = '0,
    parameter bit                     GRAY_MODE   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]      state_reg,           state_next;
    logic [N_IN-1:0] idx_reg,             idx_next;
    logic [HCW-1:0]  hold_cnt_reg,        hold_cnt_next;
    logic [N_IN-1:0] vec_reg,             vec_next;
    logic [N_IN:0]   err_count_reg,       err_count_next;
    logic [N_IN-1:0] first_err_vec_reg,   first_err_vec_next;
    logic            first_err_valid_reg, first_err_valid_next;

    // vec_out is registered alongside idx, so the encoding is applied to the
    // incremented index rather than to the current one.
    logic [N_IN-1:0] idx_inc;
    logic [N_IN-1:0] vec_of_inc;

    assign idx_inc = idx_reg + 1'b1;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_encode
            if (GRAY_MODE && (gi < N_IN - 1)) begin : g_gray
                assign vec_of_inc[gi] = idx_inc[gi] ^ idx_inc[gi+1];
            end else begin : g_plain
                assign vec_of_inc[gi] = idx_inc[gi];
            end
        end
    endgenerate

    logic sample_hit;
    logic mismatch;
    logic last_vec;

    assign sample_hit = (hold_cnt_reg == HOLD_LAST);
    // The truth table is indexed by the value actually applied, which differs
    // from idx in Gray mode.
    assign mismatch   = (dut_out != EXP_TABLE[vec_reg]);
    assign last_vec   = (idx_reg == {N_IN{1'b1}});

    always_comb begin
        state_next           = state_reg;
        idx_next             = idx_reg;
        hold_cnt_next        = hold_cnt_reg;
        vec_next             = vec_reg;
        err_count_next       = err_count_reg;
        first_err_vec_next   = first_err_vec_reg;
        first_err_valid_next = first_err_valid_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next           = ST_DRIVE;
                    idx_next             = '0;
                    hold_cnt_next        = '0;
                    vec_next             = '0;
                    err_count_next       = '0;
                    first_err_vec_next   = '0;
                    first_err_valid_next = 1'b0;
                end
            end

            ST_DRIVE: begin
                if (abort) begin
                    // Abort takes priority over start and over a final sample.
                    state_next           = ST_IDLE;
                    idx_next             = '0;
                    hold_cnt_next        = '0;
                    vec_next             = '0;
                    err_count_next       = '0;
                    first_err_vec_next   = '0;
                    first_err_valid_next = 1'b0;
                end else if (sample_hit) begin
                    if (mismatch) begin
                        err_count_next = err_count_reg + 1'b1;
                        if (!first_err_valid_reg) begin
                            first_err_vec_next   = vec_reg;
                            first_err_valid_next = 1'b1;
                        end
                    end
                    hold_cnt_next = '0;
                    if (last_vec) begin
                        // vec_out keeps the final vector while results hold.
                        state_next = ST_DONE;
                    end else begin
                        idx_next = idx_inc;
                        vec_next = vec_of_inc;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= ST_IDLE;
            idx_reg             <= '0;
            hold_cnt_reg        <= '0;
            vec_reg             <= '0;
            err_count_reg       <= '0;
            first_err_vec_reg   <= '0;
            first_err_valid_reg <= 1'b0;
        end else begin
            state_reg           <= state_next;
            idx_reg             <= idx_next;
            hold_cnt_reg        <= hold_cnt_next;
            vec_reg             <= vec_next;
            err_count_reg       <= err_count_next;
            first_err_vec_reg   <= first_err_vec_next;
            first_err_valid_reg <= first_err_valid_next;
        end
    end

    assign vec_out         = vec_reg;
    assign busy            = (state_reg == ST_DRIVE);
    assign done            = (state_reg == ST_DONE);
    assign pass            = (state_reg == ST_DONE) && (err_count_reg == '0);
    assign err_count       = err_count_reg;
    assign first_err_vec   = first_err_vec_reg;
    assign first_err_valid = first_err_valid_reg;

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// -----------------------------------------------------------------------------
// tb_exhaustive_vector_checker
//
// Three checker instances share clock and reset:
//   0: binary order, HOLD=10, table A5C3, ideal model (optional fault on 5)
//   1: binary order, HOLD=10, table 0F10, DUT output stuck at 0
//   2: Gray order,   HOLD=1,  table A5C3, ideal model
// Expected run results are queued when a run is started; a monitor pops and
// compares them when done rises, and also checks the vec_out trace.
// -----------------------------------------------------------------------------
module tb_exhaustive_vector_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] abort_v;
    logic       inject0;

    wire  [2:0] dut_out_v;
    wire  [2:0] busy_v;
    wire  [2:0] done_v;
    wire  [2:0] pass_v;
    wire  [2:0] fevv_v;
    wire  [3:0] vec_v [3];
    wire  [4:0] err_v [3];
    wire  [3:0] fev_v [3];

    logic [15:0] table_a = 16'hA5C3;

    assign dut_out_v[0] = table_a[vec_v[0]] ^ (inject0 && (vec_v[0] == 4'd5));
    assign dut_out_v[1] = 1'b0;
    assign dut_out_v[2] = table_a[vec_v[2]];

    exhaustive_vector_checker #(
        .N_IN(4), .HOLD_CYCLES(10), .EXP_TABLE(16'hA5C3), .GRAY_MODE(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .vec_out(vec_v[0]), .dut_out(dut_out_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
        .first_err_vec(fev_v[0]), .first_err_valid(fevv_v[0])
    );

    exhaustive_vector_checker #(
        .N_IN(4), .HOLD_CYCLES(10), .EXP_TABLE(16'h0F10), .GRAY_MODE(1'b0)
    ) u_dut_stuck (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .vec_out(vec_v[1]), .dut_out(dut_out_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
        .first_err_vec(fev_v[1]), .first_err_valid(fevv_v[1])
    );

    exhaustive_vector_checker #(
        .N_IN(4), .HOLD_CYCLES(1), .EXP_TABLE(16'hA5C3), .GRAY_MODE(1'b1)
    ) u_dut_gray (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
        .vec_out(vec_v[2]), .dut_out(dut_out_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
        .first_err_vec(fev_v[2]), .first_err_valid(fevv_v[2])
    );

    typedef struct {
        int pass;
        int err;
        int fev;
        int fevv;
        int cycles;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_fail   = 0;

    int gray_seq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int i, input int p, input int e, input int fv,
                            input int fvv, input int cyc);
        exp_t x;
        x.pass = p; x.err = e; x.fev = fv; x.fevv = fvv; x.cycles = cyc;
        case (i)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    // Vector expected on the k-th busy cycle of instance i.
    function automatic int expected_vec(input int i, input int k);
        int hold;
        int s;
        hold = (i == 2) ? 1 : 10;
        s = k / hold;
        if (s > 15) return -1;
        return (i == 2) ? gray_seq[s] : s;
    endfunction

    // Monitor / scoreboard
    initial begin
        int   cnt[3];
        int   terr[3];
        bit   pb[3];
        bit   pd[3];
        exp_t e;
        bit   got;
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0; terr[i] = 0; pb[i] = 1'b0; pd[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst_n !== 1'b1) begin
                    cnt[i] = 0; terr[i] = 0; pb[i] = 1'b0; pd[i] = 1'b0;
                end else begin
                    if (busy_v[i] === 1'b1) begin
                        if (!pb[i]) begin
                            cnt[i]  = 0;
                            terr[i] = 0;
                        end
                        if (int'(vec_v[i]) != expected_vec(i, cnt[i])) terr[i]++;
                        cnt[i]++;
                    end
                    if (done_v[i] === 1'b1 && !pd[i]) begin
                        got = 1'b0;
                        case (i)
                            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                        endcase
                        if (!got) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL inst%0d unexpected done: got done=1, want no run pending", i);
                        end else begin
                            $display("run inst%0d: cycles=%0d err_count=%0d first_err_vec=%0d first_err_valid=%0d pass=%0d trace_errors=%0d",
                                     i, cnt[i], err_v[i], fev_v[i], fevv_v[i], pass_v[i], terr[i]);
                            check($sformatf("inst%0d run length", i), cnt[i], e.cycles);
                            check($sformatf("inst%0d pass", i), int'(pass_v[i]), e.pass);
                            check($sformatf("inst%0d err_count", i), int'(err_v[i]), e.err);
                            check($sformatf("inst%0d first_err_vec", i), int'(fev_v[i]), e.fev);
                            check($sformatf("inst%0d first_err_valid", i), int'(fevv_v[i]), e.fevv);
                            check($sformatf("inst%0d vec_out trace errors", i), terr[i], 0);
                        end
                    end
                    pb[i] = (busy_v[i] === 1'b1);
                    pd[i] = (done_v[i] === 1'b1);
                end
            end
        end
    end

    task automatic pulse_start(input int i);
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        while (done_v[i] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_v[i] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL inst%0d done timeout: got done=0, want done=1 within %0d cycles", i, budget);
        end
    endtask

    task automatic wait_vec(input int i, input int v, input int budget);
        int n;
        n = 0;
        while (int'(vec_v[i]) != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (int'(vec_v[i]) != v) begin
            n_checks++;
            n_fail++;
            $display("FAIL inst%0d vec_out wait: got %0d, want %0d within %0d cycles", i, vec_v[i], v, budget);
        end
    endtask

    task automatic check_idle(input string tag, input int i);
        check({tag, " busy"}, int'(busy_v[i]), 0);
        check({tag, " done"}, int'(done_v[i]), 0);
        check({tag, " pass"}, int'(pass_v[i]), 0);
        check({tag, " vec_out"}, int'(vec_v[i]), 0);
        check({tag, " err_count"}, int'(err_v[i]), 0);
        check({tag, " first_err_vec"}, int'(fev_v[i]), 0);
        check({tag, " first_err_valid"}, int'(fevv_v[i]), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        abort_v = '0;
        inject0 = 1'b0;

        repeat (3) @(negedge clk);
        check_idle("reset inst0", 0);
        check_idle("reset inst2", 2);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ideal run; a start pulse mid-run must not change the run length.
        push_exp(0, 1, 0, 0, 0, 160);
        pulse_start(0);
        repeat (48) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 400);
        check("inst0 vec_out held in DONE", int'(vec_v[0]), 15);

        // abort in DONE is ignored
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check("inst0 done after abort in DONE", int'(done_v[0]), 1);
        check("inst0 vec_out after abort in DONE", int'(vec_v[0]), 15);

        // Single fault on vector 5, restarted directly from DONE
        inject0 = 1'b1;
        push_exp(0, 0, 1, 5, 1, 160);
        pulse_start(0);
        wait_done(0, 400);
        inject0 = 1'b0;

        // Stuck-at-0 against table 0F10
        push_exp(1, 0, 5, 4, 1, 160);
        pulse_start(1);
        wait_done(1, 400);

        // Gray order, one vector per clock
        push_exp(2, 1, 0, 0, 0, 16);
        pulse_start(2);
        wait_done(2, 100);
        check("inst2 vec_out held in DONE", int'(vec_v[2]), 8);

        // Abort (with a simultaneous start) while vec_out = 8
        inject0 = 1'b1;
        pulse_start(0);
        wait_vec(0, 8, 200);
        check("inst0 err_count before abort", int'(err_v[0]), 1);
        abort_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        start_v[0] = 1'b0;
        check_idle("after abort", 0);
        inject0 = 1'b0;
        push_exp(0, 1, 0, 0, 0, 160);
        pulse_start(0);
        wait_done(0, 400);

        // Asynchronous reset mid-run while vec_out = 11
        inject0 = 1'b1;
        pulse_start(0);
        wait_vec(0, 11, 200);
        #2 rst_n = 1'b0;
        #1 check_idle("async reset", 0);
        @(negedge clk);
        rst_n   = 1'b1;
        inject0 = 1'b0;
        push_exp(0, 1, 0, 0, 0, 160);
        pulse_start(0);
        wait_done(0, 400);

        repeat (3) @(negedge clk);
        check("inst0 pending results", q0.size(), 0);
        check("inst1 pending results", q1.size(), 0);
        check("inst2 pending results", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
